// File: rtl/uprog_dispatcher.sv
// uprog_dispatcher: round-robin command dispatcher in front of the microcode
// sequencer. Looks up entry uPC and loop bounds for the winning request's
// program ID, launches the sequencer, and returns a completion pulse.
module uprog_dispatcher #(
  parameter int UINST_ADDR_WIDTH = 9,
  parameter int NUM_REQ          = 4,
  parameter int NUM_PROG         = 8,
  localparam int PW              = $clog2(NUM_PROG)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*PW-1:0]       req_prog,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          cmpl,
  output logic                        cmpl_err,
  output logic                        busy,
  input  logic                        cfg_we,
  input  logic [PW-1:0]               cfg_addr,
  input  logic [2:0]                  cfg_field,
  input  logic [10:0]                 cfg_wdata,
  output logic                        start_pos,
  output logic [UINST_ADDR_WIDTH-1:0] upc_start,
  output logic [10:0]                 loop_0,
  output logic [10:0]                 loop_1,
  output logic [10:0]                 loop_2,
  output logic [10:0]                 loop_3,
  output logic [10:0]                 loop_4,
  input  logic                        done
);

  localparam int RW       = $clog2(NUM_REQ);
  localparam int LW       = 11;
  localparam int NUM_LOOP = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_CMPL   = 2'd3
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic                        valid_tab_r [NUM_PROG];
  logic [UINST_ADDR_WIDTH-1:0] entry_tab_r [NUM_PROG];
  logic [LW-1:0]               loop_tab_r  [NUM_PROG][NUM_LOOP];

  logic [RW-1:0]               rr_ptr_r, rr_nxt_s, win_r, win_nxt_s, arb_win_s;
  logic                        arb_any_s;
  logic [PW-1:0]               arb_pid_s;
  logic                        err_r, err_nxt_s;
  logic [NUM_REQ-1:0]          gnt_r, gnt_nxt_s, cmpl_r, cmpl_nxt_s;
  logic                        cmpl_err_r, cmpl_err_nxt_s;
  logic                        busy_r, start_r, start_nxt_s;
  logic [UINST_ADDR_WIDTH-1:0] upc_r, upc_nxt_s;
  logic [LW-1:0]               loop_r [NUM_LOOP];
  logic [LW-1:0]               loop_nxt_s [NUM_LOOP];

  function automatic logic [NUM_REQ-1:0] onehot_req(input logic [RW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [RW-1:0] rr_idx(input logic [RW-1:0] base, input int k);
    return RW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Round-robin pick: first requester at or after rr_ptr_r, with its program ID.
  always_comb begin
    arb_any_s = 1'b0;
    arb_win_s = '0;
    arb_pid_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_any_s && req[rr_idx(rr_ptr_r, k)]) begin
        arb_any_s = 1'b1;
        arb_win_s = rr_idx(rr_ptr_r, k);
      end else begin
        arb_win_s = arb_win_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_win_s == RW'(i)) begin
        arb_pid_s = req_prog[i*PW +: PW];
      end else begin
        arb_pid_s = arb_pid_s;
      end
    end
  end

  // Next-state logic of the launch/run/complete sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (arb_any_s) state_nxt_s = ST_LAUNCH; else state_nxt_s = ST_IDLE;
      ST_LAUNCH: if (err_r)     state_nxt_s = ST_CMPL;   else state_nxt_s = ST_RUN;
      ST_RUN:    if (done)      state_nxt_s = ST_CMPL;   else state_nxt_s = ST_RUN;
      ST_CMPL:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; launch data is read from the table
  // before any same-edge write lands, so a colliding write is not seen.
  always_comb begin
    gnt_nxt_s      = '0;
    cmpl_nxt_s     = '0;
    cmpl_err_nxt_s = 1'b0;
    start_nxt_s    = 1'b0;
    upc_nxt_s      = upc_r;
    for (int l = 0; l < NUM_LOOP; l++) loop_nxt_s[l] = loop_r[l];
    err_nxt_s      = err_r;
    win_nxt_s      = win_r;
    rr_nxt_s       = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_any_s) begin
          gnt_nxt_s = onehot_req(arb_win_s);
          win_nxt_s = arb_win_s;
          rr_nxt_s  = rr_idx(arb_win_s, 1);
          if (valid_tab_r[arb_pid_s]) begin
            start_nxt_s = 1'b1;
            upc_nxt_s   = entry_tab_r[arb_pid_s];
            for (int l = 0; l < NUM_LOOP; l++) loop_nxt_s[l] = loop_tab_r[arb_pid_s][l];
            err_nxt_s   = 1'b0;
          end else begin
            err_nxt_s   = 1'b1;
          end
        end else begin
          err_nxt_s = err_r;
        end
      end
      ST_LAUNCH: begin
        if (err_r) begin
          cmpl_nxt_s     = onehot_req(win_r);
          cmpl_err_nxt_s = 1'b1;
        end else begin
          cmpl_nxt_s     = '0;
        end
      end
      ST_RUN: begin
        if (done) begin
          cmpl_nxt_s     = onehot_req(win_r);
          cmpl_err_nxt_s = err_r;
        end else begin
          cmpl_nxt_s     = '0;
        end
      end
      ST_CMPL: err_nxt_s = 1'b0;
      default: err_nxt_s = 1'b0;
    endcase
  end

  // State, arbitration pointer and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      win_r      <= '0;
      err_r      <= 1'b0;
      gnt_r      <= '0;
      cmpl_r     <= '0;
      cmpl_err_r <= 1'b0;
      busy_r     <= 1'b0;
      start_r    <= 1'b0;
      upc_r      <= '0;
      for (int l = 0; l < NUM_LOOP; l++) loop_r[l] <= '0;
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_nxt_s;
      win_r      <= win_nxt_s;
      err_r      <= err_nxt_s;
      gnt_r      <= gnt_nxt_s;
      cmpl_r     <= cmpl_nxt_s;
      cmpl_err_r <= cmpl_err_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      start_r    <= start_nxt_s;
      upc_r      <= upc_nxt_s;
      for (int l = 0; l < NUM_LOOP; l++) loop_r[l] <= loop_nxt_s[l];
    end
  end

  // Program table: one field written per cfg_we; entry writes mark the program valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NUM_PROG; p++) begin
        valid_tab_r[p] <= 1'b0;
        entry_tab_r[p] <= '0;
        for (int l = 0; l < NUM_LOOP; l++) loop_tab_r[p][l] <= '0;
      end
    end else if (cfg_we) begin
      case (cfg_field)
        3'd0: begin
          entry_tab_r[cfg_addr] <= cfg_wdata[UINST_ADDR_WIDTH-1:0];
          valid_tab_r[cfg_addr] <= 1'b1;
        end
        3'd1:    loop_tab_r[cfg_addr][0] <= cfg_wdata;
        3'd2:    loop_tab_r[cfg_addr][1] <= cfg_wdata;
        3'd3:    loop_tab_r[cfg_addr][2] <= cfg_wdata;
        3'd4:    loop_tab_r[cfg_addr][3] <= cfg_wdata;
        3'd5:    loop_tab_r[cfg_addr][4] <= cfg_wdata;
        default: begin end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign cmpl      = cmpl_r;
  assign cmpl_err  = cmpl_err_r;
  assign busy      = busy_r;
  assign start_pos = start_r;
  assign upc_start = upc_r;
  assign loop_0    = loop_r[0];
  assign loop_1    = loop_r[1];
  assign loop_2    = loop_r[2];
  assign loop_3    = loop_r[3];
  assign loop_4    = loop_r[4];

endmodule

// File: tb/tb_uprog_dispatcher.sv
// Testbench for uprog_dispatcher: a transaction-timeline reference model checks
// every cycle, plus a vector table and hand-written corner-case sequences.
module tb_uprog_dispatcher;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [11:0] req_prog;
  logic [3:0]  gnt, cmpl;
  logic        cmpl_err, busy, cfg_we, start_pos, done;
  logic [2:0]  cfg_addr, cfg_field;
  logic [10:0] cfg_wdata;
  logic [8:0]  upc_start;
  logic [10:0] loop_0, loop_1, loop_2, loop_3, loop_4;
  logic [10:0] loop_o [5];

  assign loop_o[0] = loop_0;
  assign loop_o[1] = loop_1;
  assign loop_o[2] = loop_2;
  assign loop_o[3] = loop_3;
  assign loop_o[4] = loop_4;

  uprog_dispatcher dut (
    .clk(clk), .rstn(rstn), .req(req), .req_prog(req_prog), .gnt(gnt),
    .cmpl(cmpl), .cmpl_err(cmpl_err), .busy(busy), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .start_pos(start_pos), .upc_start(upc_start), .loop_0(loop_0),
    .loop_1(loop_1), .loop_2(loop_2), .loop_3(loop_3), .loop_4(loop_4),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (job timeline) ----------------
  bit          m_valid [8];
  logic [10:0] m_entry [8];
  logic [10:0] m_loop  [8][5];
  int          cyc = 0;
  bit          m_job;
  int          m_a, m_cmpl_edge, m_free, m_who, m_rr;
  bit          m_ok;
  logic [3:0]  e_gnt, e_cmpl;
  logic        e_err, e_busy, e_start;
  logic [8:0]  e_upc;
  logic [10:0] e_loop [5];

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict outputs after the coming clock edge from the inputs now applied.
  task automatic predict();
    int w;
    logic [2:0] pid;
    cyc++;
    e_gnt = 4'd0; e_cmpl = 4'd0; e_err = 1'b0; e_start = 1'b0;
    if (!rstn) begin
      m_job = 1'b0; m_rr = 0; e_busy = 1'b0; e_upc = 9'd0;
      for (int p = 0; p < 8; p++) begin
        m_valid[p] = 1'b0; m_entry[p] = 11'd0;
        for (int l = 0; l < 5; l++) m_loop[p][l] = 11'd0;
      end
      for (int l = 0; l < 5; l++) e_loop[l] = 11'd0;
      return;
    end
    if (m_job && cyc == m_free) m_job = 1'b0;
    if (!m_job) begin
      if (req != 4'd0) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
        pid   = req_prog[w*3 +: 3];
        m_job = 1'b1; m_a = cyc; m_who = w; m_ok = m_valid[pid];
        m_rr  = (w + 1) % 4;
        e_gnt = oh(w);
        if (m_ok) begin
          e_start = 1'b1;
          e_upc   = m_entry[pid][8:0];
          for (int l = 0; l < 5; l++) e_loop[l] = m_loop[pid][l];
          m_cmpl_edge = -1;
        end else begin
          m_cmpl_edge = cyc + 1;
          m_free      = cyc + 3;
        end
      end
    end else if (m_ok && m_cmpl_edge < 0 && cyc >= m_a + 2 && done) begin
      m_cmpl_edge = cyc;
      m_free      = cyc + 2;
    end
    if (m_job && cyc == m_cmpl_edge) begin
      e_cmpl = oh(m_who);
      e_err  = !m_ok;
    end
    e_busy = m_job && (m_cmpl_edge < 0 || cyc <= m_cmpl_edge);
    if (cfg_we) begin
      if (cfg_field == 3'd0) begin
        m_entry[cfg_addr] = cfg_wdata;
        m_valid[cfg_addr] = 1'b1;
      end else if (cfg_field <= 3'd5) begin
        m_loop[cfg_addr][cfg_field - 3'd1] = cfg_wdata;
      end
    end
  endtask

  // One clock: predict, wait the edge, sample 1 ns later and compare all outputs.
  task automatic step();
    predict();
    @(posedge clk);
    #1;
    chk("m_gnt", 32'(gnt), 32'(e_gnt));
    chk("m_cmpl", 32'(cmpl), 32'(e_cmpl));
    chk("m_cmpl_err", 32'(cmpl_err), 32'(e_err));
    chk("m_busy", 32'(busy), 32'(e_busy));
    chk("m_start_pos", 32'(start_pos), 32'(e_start));
    chk("m_upc_start", 32'(upc_start), 32'(e_upc));
    for (int l = 0; l < 5; l++) chk($sformatf("m_loop_%0d", l), 32'(loop_o[l]), 32'(e_loop[l]));
  endtask

  task automatic cfg_write(input int a, input int f, input int d);
    cfg_addr = 3'(a); cfg_field = 3'(f); cfg_wdata = 11'(d); cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [1:0]       who;
    logic [2:0]       pid;
    logic [7:0]       run_len;
    logic             exp_err;
    logic [8:0]       exp_upc;
    logic [4:0][10:0] exp_loop;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mkv(input int who, input int pid, input int run, input bit err,
                               input int upc, input int l0, input int l1, input int l2,
                               input int l3, input int l4);
    vec_t v;
    v.who = 2'(who); v.pid = 3'(pid); v.run_len = 8'(run); v.exp_err = err;
    v.exp_upc = 9'(upc);
    v.exp_loop[0] = 11'(l0); v.exp_loop[1] = 11'(l1); v.exp_loop[2] = 11'(l2);
    v.exp_loop[3] = 11'(l3); v.exp_loop[4] = 11'(l4);
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    req[v.who] = 1'b1;
    req_prog[v.who*3 +: 3] = v.pid;
    step();
    chk("vec_gnt", 32'(gnt), 32'(oh(v.who)));
    chk("vec_start", 32'(start_pos), 32'(!v.exp_err));
    chk("vec_upc", 32'(upc_start), 32'(v.exp_upc));
    for (int l = 0; l < 5; l++) chk($sformatf("vec_loop_%0d", l), 32'(loop_o[l]), 32'(v.exp_loop[l]));
    chk("vec_busy_launch", 32'(busy), 32'd1);
    req[v.who] = 1'b0;
    if (v.exp_err) begin
      step();
      chk("vec_cmpl_err_pulse", 32'(cmpl), 32'(oh(v.who)));
      chk("vec_cmpl_err", 32'(cmpl_err), 32'd1);
    end else begin
      for (int c = 0; c < int'(v.run_len); c++) step();
      chk("vec_no_early_cmpl", 32'(cmpl), 32'd0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("vec_cmpl", 32'(cmpl), 32'(oh(v.who)));
      chk("vec_cmpl_err_clr", 32'(cmpl_err), 32'd0);
      chk("vec_busy_cmpl", 32'(busy), 32'd1);
    end
    step();
    chk("vec_busy_drop", 32'(busy), 32'd0);
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int order [$];
  int since, starts;

  initial begin
    rstn = 1'b0; req = 4'd0; req_prog = 12'd0; cfg_we = 1'b0;
    cfg_addr = 3'd0; cfg_field = 3'd0; cfg_wdata = 11'd0; done = 1'b0;
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upc", 32'(upc_start), 32'd0);

    // Table setup: prog 2, prog 1, prog 3 without entry, ignored fields.
    cfg_write(2, 0, 'h040);
    cfg_write(2, 1, 3); cfg_write(2, 2, 5); cfg_write(2, 3, 7);
    cfg_write(2, 4, 9); cfg_write(2, 5, 11);
    cfg_write(1, 0, 'h100);
    cfg_write(1, 1, 1); cfg_write(1, 2, 2); cfg_write(1, 3, 4);
    cfg_write(1, 4, 6); cfg_write(1, 5, 8);
    cfg_write(3, 1, 5); cfg_write(2, 6, 'h7ff); cfg_write(2, 7, 'h7ff);

    vecs[0] = mkv(1, 2, 20, 1'b0, 'h040, 3, 5, 7, 9, 11);
    vecs[1] = mkv(0, 5,  0, 1'b1, 'h040, 3, 5, 7, 9, 11);
    vecs[2] = mkv(3, 1,  4, 1'b0, 'h100, 1, 2, 4, 6, 8);
    vecs[3] = mkv(2, 7,  0, 1'b1, 'h100, 1, 2, 4, 6, 8);
    vecs[4] = mkv(2, 2,  1, 1'b0, 'h040, 3, 5, 7, 9, 11);
    vecs[5] = mkv(1, 3,  0, 1'b1, 'h040, 3, 5, 7, 9, 11);
    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Config during run, and write colliding with launch.
    req[0] = 1'b1; req_prog[2:0] = 3'd1;
    step();
    chk("cdr_launch_loop2", 32'(loop_2), 32'd4);
    req[0] = 1'b0;
    step();
    cfg_write(1, 3, 8);
    step();
    chk("cdr_run_loop2", 32'(loop_2), 32'd4);
    done = 1'b1; step(); done = 1'b0; step();
    req[0] = 1'b1;
    cfg_addr = 3'd1; cfg_field = 3'd3; cfg_wdata = 11'd12; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("cdr_relaunch_loop2", 32'(loop_2), 32'd8);
    req[0] = 1'b0;
    step(); done = 1'b1; step(); done = 1'b0; step();
    req[0] = 1'b1;
    step();
    chk("cdr_third_loop2", 32'(loop_2), 32'd12);
    req[0] = 1'b0;
    step(); done = 1'b1; step(); done = 1'b0; step();

    // Stray done in IDLE and in the LAUNCH cycle.
    done = 1'b1; step(); done = 1'b0;
    chk("stray_idle_cmpl", 32'(cmpl), 32'd0);
    chk("stray_idle_busy", 32'(busy), 32'd0);
    req[2] = 1'b1; req_prog[8:6] = 3'd2;
    step();
    req[2] = 1'b0;
    done = 1'b1; step(); done = 1'b0;
    chk("stray_launch_cmpl", 32'(cmpl), 32'd0);
    step(); step();
    chk("stray_run_cmpl", 32'(cmpl), 32'd0);
    chk("stray_run_busy", 32'(busy), 32'd1);
    done = 1'b1; step(); done = 1'b0;
    chk("stray_late_cmpl", 32'(cmpl), 32'(oh(2)));
    step();

    // Asynchronous reset while running.
    req[1] = 1'b1; req_prog[5:3] = 3'd2;
    step();
    req[1] = 1'b0;
    step(); step();
    rstn = 1'b0;
    #1;
    chk("arst_busy_async", 32'(busy), 32'd0);
    chk("arst_loop0_async", 32'(loop_0), 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    chk("arst_no_cmpl", 32'(cmpl), 32'd0);
    chk("arst_upc", 32'(upc_start), 32'd0);
    req[0] = 1'b1; req_prog[2:0] = 3'd2;
    step();
    chk("arst_gnt", 32'(gnt), 32'(oh(0)));
    chk("arst_no_start", 32'(start_pos), 32'd0);
    req[0] = 1'b0;
    step();
    chk("arst_cmpl_err", 32'({cmpl, cmpl_err}), 32'({oh(0), 1'b1}));
    step();

    // Round robin with all four requesters holding.
    do_reset();
    cfg_write(2, 0, 'h040); cfg_write(2, 1, 3);
    req_prog = {4{3'd2}};
    req = 4'b1111;
    since = -1; starts = 0;
    for (int k = 0; k < 100 && order.size() < 5; k++) begin
      done = (since == 2);
      step();
      done = 1'b0;
      if (since >= 0) since++;
      if (start_pos) starts++;
      if (gnt != 4'd0) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) begin order.push_back(i); req[i] = 1'b0; end
        since = 0;
      end
      if (cmpl != 4'd0) begin req = 4'b1111; since = -1; end
    end
    req = 4'd0;
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++) chk($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(rr_exp[i]));
    chk("rr_starts", 32'(starts), 32'd5);
    step(); done = 1'b1; step(); done = 1'b0; step(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      done   = ($urandom_range(0, 4) == 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_field = 3'($urandom_range(0, 7));
      cfg_wdata = 11'($urandom);
      step();
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_prog[i*3 +: 3] = 3'($urandom_range(0, 7));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/uprog_dispatcher.md
# uprog_dispatcher

Command dispatcher in front of the microcode sequencer. Arbitrates round-robin between up to NUM_REQ operation requesters (e.g. KeyGen/Encaps/Decaps front-ends). It maps each request's program ID to an entry uPC and five loop bounds held in a software-configurable program table. It launches the sequencer with a one-cycle start pulse, holds the loop bounds stable for the whole run, and returns a completion pulse to the granted requester when the sequencer signals done.

## Interface
Parameters:
- UINST_ADDR_WIDTH, 9: microcode address width (width of upc_start).
- NUM_REQ, 4: number of requesters (2..8).
- NUM_PROG, 8: program table depth; program ID width PW = 3.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  level request per requester; held until gnt, dropped the cycle after gnt.
- req_prog  in  NUM_REQ*PW  program ID per requester; slice i = [i*PW +: PW]; stable while req[i]=1.
- gnt  out  NUM_REQ  one-hot, 1-cycle grant pulse.
- cmpl  out  NUM_REQ  one-hot, 1-cycle completion pulse to the granted requester.
- cmpl_err  out  1  qualifies a cmpl pulse: program ID not configured.
- busy  out  1  high from grant until cmpl, inclusive.
- cfg_we  in  1  program-table write strobe.
- cfg_addr  in  PW  program ID written.
- cfg_field  in  3  0 = entry uPC, 1..5 = loop_0..loop_4 bound; 6,7 = write ignored.
- cfg_wdata  in  11  write data; entry uses [UINST_ADDR_WIDTH-1:0].
- start_pos  out  1  1-cycle sequencer start pulse.
- upc_start  out  UINST_ADDR_WIDTH  entry uPC, valid with start_pos, held until next launch.
- loop_0..loop_4  out  11 each  loop bounds of the active program; registered.
- done  in  1  sequencer completion.

## Operation
- Table: NUM_PROG entries × {valid, entry, loop_0..4}. cfg_we writes one field on the clock edge. A write to field 0 sets that entry's valid bit. Writes are accepted in any state.
- Loop and entry values are copied into output registers at launch, so table writes never disturb a running program.
- Simultaneous cfg write and launch of the same program ID: the launch uses the pre-write value.
- FSM states IDLE, LAUNCH, RUN, CMPL.
  - IDLE: if any req bit is set, pick winner w round-robin starting at rr_ptr, capture pid = req_prog[w] and go to LAUNCH. rr_ptr <= (w+1) mod NUM_REQ.
  - LAUNCH (one cycle): assert gnt[w]. If valid[pid], assert start_pos, drive upc_start/loop_* from the table and go to RUN. Otherwise leave loop_* unchanged and go to CMPL with the err flag set.
  - RUN: wait for done. On done go to CMPL.
  - CMPL (one cycle): assert cmpl[w], plus cmpl_err if the err flag is set. Clear the err flag and go to IDLE.
- done is ignored outside RUN, including in the LAUNCH cycle.
- busy = (state != IDLE).
- Requests arriving while busy wait; they are not dropped.
- Reset mid-run forces IDLE and all outputs to reset values. No cmpl is issued for the aborted command.
- Reset values: gnt, cmpl, cmpl_err, busy, start_pos = 0; upc_start = 0; loop_0..4 = 0; rr_ptr = 0; table valid bits and all fields = 0.

## Timing
- All outputs are registered.
- req high at edge T (state IDLE): LAUNCH in cycle T+1, with gnt, start_pos, upc_start and loop_* valid in that same cycle.
- The sequencer enters its run state at edge T+2.
- done sampled high in RUN at edge D: cmpl at cycle D+1; IDLE at D+2.
- Earliest next grant: req sampled at D+2, gnt at D+3.
- Minimum request-to-completion latency: 3 cycles plus sequencer run time.
- Invalid program: gnt at T+1, cmpl and cmpl_err at T+2, start_pos never asserted.
- Requesters must drop req in the cycle after gnt. A req still high when the FSM returns to IDLE is a new request.

## Test plan
- Config then run: write prog 2 entry=0x040 and loop_0..4 = 3,5,7,9,11; req[1] with prog 2 → gnt[1] and start_pos in the same cycle, upc_start=0x040, loop_0..4 = 3,5,7,9,11. done after 20 cycles → cmpl[1] next cycle, cmpl_err=0, busy drops one cycle later.
- Round-robin: req=4'b1111 held (each requester drops only after its own gnt, then re-requests) → grants in order 0,1,2,3,0. Only one start_pos is outstanding at a time.
- Unconfigured program: after reset, req[0] with prog 5 → gnt[0], then cmpl[0] with cmpl_err=1 the next cycle; start_pos stays 0.
- Config during run: launch prog 1 with loop_2=4, then during RUN write prog 1 loop_2=8 → loop_2 output stays 4 until the next launch; the re-launch of prog 1 shows 8. A write to prog 1 in the same cycle as the prog 1 launch → launch uses the old value.
- Stray done: pulse done in IDLE and in the LAUNCH cycle → no cmpl is issued and the FSM stays in RUN until a later done.
- Async reset in RUN: deassert rstn for 2 cycles → all outputs 0, table invalid, no cmpl; a subsequent request behaves as the unconfigured-program case.
